// File: rtl/histogram_stream_if.sv
// Pixel-in / histogram-out stream bundle for histogram_stream.
// Signal suffixes are from the histogram unit's point of view.
interface histogram_stream_if #(
   parameter int C_DATA_WIDTH  = 8,
   parameter int C_BINS        = 256,
   parameter int C_COUNT_WIDTH = 20
);
   localparam int BW = $clog2(C_BINS);

   logic                     valid_i;
   logic                     ready_o;
   logic [C_DATA_WIDTH-1:0]  data_i;
   logic                     last_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [BW-1:0]            bin_o;
   logic [C_COUNT_WIDTH-1:0] count_o;
   logic                     last_o;
   logic                     busy_o;

   modport slave (
      input  valid_i, data_i, last_i, ready_i,
      output ready_o, valid_o, bin_o, count_o, last_o, busy_o
   );

   modport master (
      output valid_i, data_i, last_i, ready_i,
      input  ready_o, valid_o, bin_o, count_o, last_o, busy_o
   );
endinterface

// File: rtl/histogram_stream.sv
// Streaming histogram: bins pixels into a RAM, then streams bins out with read-and-clear.
// Optional macro HIST_CDF_EN: count_o carries the saturating cumulative sum instead of raw counts.
module histogram_stream #(
   parameter int C_DATA_WIDTH  = 8,
   parameter int C_BINS        = 256,
   parameter int C_COUNT_WIDTH = 20
) (
   input logic               clk_i,
   input logic               rstn_i,
   histogram_stream_if.slave bus
);
   localparam int BW = $clog2(C_BINS);
   localparam logic [BW-1:0]            BIN_MAX = '1;
   localparam logic [C_COUNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_READOUT} state_e;

   state_e                   state_q, state_d;
   logic [BW-1:0]            clr_q, clr_d;
   logic                     drain_q, drain_d;
   logic                     s1_vld_q, s1_vld_d;
   logic [BW-1:0]            s1_bin_q, s1_bin_d;
   logic                     wr_vld_q, wr_vld_d;
   logic [BW-1:0]            wr_bin_q, wr_bin_d;
   logic [C_COUNT_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [BW:0]              ra_q, ra_d;
   logic                     p_vld_q, p_vld_d;
   logic [BW-1:0]            p_bin_q, p_bin_d;
   logic                     out_vld_q, out_vld_d;
   logic [BW-1:0]            out_bin_q, out_bin_d;
   logic [C_COUNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                     out_last_q, out_last_d;
`ifdef HIST_CDF_EN
   logic [C_COUNT_WIDTH-1:0] cdf_q, cdf_d;
   logic [C_COUNT_WIDTH:0]   cdf_sum;
   logic [C_COUNT_WIDTH-1:0] cdf_sat;
`endif

   logic [C_COUNT_WIDTH-1:0] mem_q [C_BINS];
   logic [C_COUNT_WIDTH-1:0] rd_data_q;
   logic                     mem_we, rd_en;
   logic [BW-1:0]            mem_waddr, rd_addr;
   logic [C_COUNT_WIDTH-1:0] mem_wdata;

   logic                     beat, out_load, p_free, issue;
   logic [BW-1:0]            in_bin;
   logic [C_COUNT_WIDTH-1:0] acc_old, acc_new;

   assign beat    = bus.valid_i && (state_q == S_ACCUM);
   assign in_bin  = bus.data_i[C_DATA_WIDTH-1 -: BW];
   // The previous cycle's write is not yet visible in rd_data_q, so forward it.
   assign acc_old = (wr_vld_q && (wr_bin_q == s1_bin_q)) ? wr_data_q : rd_data_q;
   assign acc_new = (acc_old == CNT_MAX) ? acc_old : acc_old + CNT_ONE;

   assign out_load = !out_vld_q || bus.ready_i;
   assign p_free   = !p_vld_q || out_load;
   assign issue    = (state_q == S_READOUT) && p_free && !ra_q[BW];

`ifdef HIST_CDF_EN
   assign cdf_sum = {1'b0, cdf_q} + {1'b0, rd_data_q};
   assign cdf_sat = cdf_sum[C_COUNT_WIDTH] ? CNT_MAX : cdf_sum[C_COUNT_WIDTH-1:0];
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      clr_d      = clr_q;
      drain_d    = drain_q;
      ra_d       = ra_q;
      p_vld_d    = p_vld_q;
      p_bin_d    = p_bin_q;
      out_vld_d  = out_vld_q;
      out_bin_d  = out_bin_q;
      out_cnt_d  = out_cnt_q;
      out_last_d = out_last_q;
`ifdef HIST_CDF_EN
      cdf_d      = cdf_q;
`endif
      s1_vld_d   = beat;
      s1_bin_d   = in_bin;
      wr_vld_d   = s1_vld_q;
      wr_bin_d   = s1_bin_q;
      wr_data_d  = acc_new;
      rd_en      = beat;
      rd_addr    = in_bin;
      mem_we     = s1_vld_q;
      mem_waddr  = s1_bin_q;
      mem_wdata  = acc_new;

      unique case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
            mem_wdata = '0;
            clr_d     = clr_q + 1'b1;
            if (clr_q == BIN_MAX) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            drain_d = 1'b0;
            if (beat && bus.last_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            drain_d   = 1'b1;
            ra_d      = '0;
            p_vld_d   = 1'b0;
            out_vld_d = 1'b0;
`ifdef HIST_CDF_EN
            cdf_d     = '0;
`endif
            if (drain_q) state_d = S_READOUT;
         end
         S_READOUT: begin
            if (out_load) begin
               out_vld_d = p_vld_q;
               if (p_vld_q) begin
                  out_bin_d  = p_bin_q;
                  out_last_d = (p_bin_q == BIN_MAX);
`ifdef HIST_CDF_EN
                  out_cnt_d  = cdf_sat;
                  cdf_d      = cdf_sat;
`else
                  out_cnt_d  = rd_data_q;
`endif
               end
            end
            if (p_free) p_vld_d = issue;
            if (issue) begin
               rd_en     = 1'b1;
               rd_addr   = ra_q[BW-1:0];
               mem_we    = 1'b1;
               mem_waddr = ra_q[BW-1:0];
               mem_wdata = '0;
               ra_d      = ra_q + 1'b1;
               p_bin_d   = ra_q[BW-1:0];
            end
            if (out_vld_q && bus.ready_i && out_last_q) begin
               state_d   = S_ACCUM;
               out_vld_d = 1'b0;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_CLEAR;
         clr_q      <= '0;
         drain_q    <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_bin_q   <= '0;
         wr_vld_q   <= 1'b0;
         wr_bin_q   <= '0;
         wr_data_q  <= '0;
         ra_q       <= '0;
         p_vld_q    <= 1'b0;
         p_bin_q    <= '0;
         out_vld_q  <= 1'b0;
         out_bin_q  <= '0;
         out_cnt_q  <= '0;
         out_last_q <= 1'b0;
`ifdef HIST_CDF_EN
         cdf_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         clr_q      <= clr_d;
         drain_q    <= drain_d;
         s1_vld_q   <= s1_vld_d;
         s1_bin_q   <= s1_bin_d;
         wr_vld_q   <= wr_vld_d;
         wr_bin_q   <= wr_bin_d;
         wr_data_q  <= wr_data_d;
         ra_q       <= ra_d;
         p_vld_q    <= p_vld_d;
         p_bin_q    <= p_bin_d;
         out_vld_q  <= out_vld_d;
         out_bin_q  <= out_bin_d;
         out_cnt_q  <= out_cnt_d;
         out_last_q <= out_last_d;
`ifdef HIST_CDF_EN
         cdf_q      <= cdf_d;
`endif
      end
   end

   // NOTE: the bin RAM is not reset; the CLEAR sweep initialises it so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      if (rd_en)  rd_data_q <= mem_q[rd_addr];
   end

   assign bus.ready_o = (state_q == S_ACCUM);
   assign bus.busy_o  = (state_q != S_ACCUM);
   assign bus.valid_o = out_vld_q;
   assign bus.bin_o   = out_bin_q;
   assign bus.count_o = out_cnt_q;
   assign bus.last_o  = out_last_q;
endmodule
